fetch_stage: RTL and testbench

- Instruction-fetch stage of the core_lapido pipeline. It consumes the registered redirect interface driven by the memory stage: branch taken, branch address, jump flag and jump address.
- Owns the PC register and drives the synchronous instruction memory address. Presents the fetched instruction, its PC and PC+1 to the IF/ID boundary.
- Asserts a flush pulse to younger stages whenever a redirect is accepted.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of the core_lapido pipeline.
//
// Owns the PC and drives a synchronous instruction memory with a one-cycle
// read latency. It presents the fetched instruction, its PC and PC+1 to the
// IF/ID boundary. A redirect (jump or taken branch) from the memory stage
// reloads the PC, inserts one bubble and pulses out_flush to the younger
// stages.
//
// Parameters
//   PC_WIDTH  width of the PC and of the instruction memory address
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   in_stall              hazard stall, hold fetch state
//   in_branch_taken/addr  taken conditional branch and its target
//   in_is_jump/jump_addr  unconditional jump; low PC_WIDTH bits of target used
//   imem_addr / imem_data memory address (combinational) / read data
//   out_instr, out_pc, out_next_pc, out_valid   IF/ID payload
//   out_flush             squash IF/ID, ID/EX and EX/MEM this cycle
//   out_branch_count, out_jump_count  redirect statistics
//
// Optional feature: define FETCH_REDIRECT_STATS_EN to build saturating
// 16-bit counters of accepted branch and jump redirects. Without it both
// count ports are tied to zero.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned             PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_stall,
  input  logic                in_branch_taken,
  input  logic [PC_WIDTH-1:0] in_branch_addr,
  input  logic                in_is_jump,
  input  logic [31:0]         in_jump_addr,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [31:0]         out_instr,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [PC_WIDTH-1:0] out_next_pc,
  output logic                out_valid,
  output logic                out_flush,
  output logic [15:0]         out_branch_count,
  output logic [15:0]         out_jump_count
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_BUBBLE
  } state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] fetched_pc_q, fetched_pc_d;
  logic                fetch_valid_q, fetch_valid_d;

  logic                redirect;
  logic [PC_WIDTH-1:0] target;

  // Upper jump-address bits are architecturally ignored when PC_WIDTH < 32.
  logic unused_jump_bits;
  assign unused_jump_bits = ^in_jump_addr;

  assign redirect = in_is_jump | in_branch_taken;
  // Jump wins over a simultaneous taken branch.
  assign target   = in_is_jump ? in_jump_addr[PC_WIDTH-1:0] : in_branch_addr;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetched_pc_d  = fetched_pc_q;
    fetch_valid_d = fetch_valid_q;
    if (redirect) begin
      // A redirect overrides a simultaneous stall.
      pc_d          = target;
      fetched_pc_d  = pc_q;
      fetch_valid_d = 1'b0;
      state_d       = ST_BUBBLE;
    end else if (!in_stall) begin
      pc_d          = pc_q + PC_ONE;
      fetched_pc_d  = pc_q;
      fetch_valid_d = 1'b1;
      state_d       = ST_RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetched_pc_q  <= RESET_PC;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetched_pc_q  <= fetched_pc_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // During a plain stall re-read the held instruction so imem_data keeps it.
  assign imem_addr   = (in_stall && !redirect) ? fetched_pc_q : pc_q;

  assign out_pc      = fetched_pc_q;
  assign out_next_pc = fetched_pc_q + PC_ONE;
  assign out_valid   = fetch_valid_q & ~redirect;
  assign out_instr   = out_valid ? imem_data : 32'd0;
  assign out_flush   = redirect & ~rst;

`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0] branch_cnt_q, branch_cnt_d;
  logic [15:0] jump_cnt_q, jump_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    jump_cnt_d   = jump_cnt_q;
    if (in_is_jump) begin
      if (jump_cnt_q != 16'hFFFF) jump_cnt_d = jump_cnt_q + 16'd1;
    end else if (in_branch_taken) begin
      if (branch_cnt_q != 16'hFFFF) branch_cnt_d = branch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= 16'd0;
      jump_cnt_q   <= 16'd0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      jump_cnt_q   <= jump_cnt_d;
    end
  end

  assign out_branch_count = branch_cnt_q;
  assign out_jump_count   = jump_cnt_q;
`else
  assign out_branch_count = 16'd0;
  assign out_jump_count   = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage -- self-checking bench for fetch_stage.
// Main instance: PC_WIDTH=16, RESET_PC=0. Second instance: PC_WIDTH=4,
// RESET_PC=14, used for the PC wrap-around sequence.
// The instruction memory returns address+100 one cycle after the address.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        rst, in_stall, in_branch_taken, in_is_jump;
  logic [15:0] in_branch_addr;
  logic [31:0] in_jump_addr;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] out_instr;
  logic [15:0] out_pc, out_next_pc;
  logic        out_valid, out_flush;
  logic [15:0] out_branch_count, out_jump_count;

  fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'd0)) u_dut (
    .clk(clk), .rst(rst), .in_stall(in_stall),
    .in_branch_taken(in_branch_taken), .in_branch_addr(in_branch_addr),
    .in_is_jump(in_is_jump), .in_jump_addr(in_jump_addr),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_instr(out_instr), .out_pc(out_pc), .out_next_pc(out_next_pc),
    .out_valid(out_valid), .out_flush(out_flush),
    .out_branch_count(out_branch_count), .out_jump_count(out_jump_count)
  );

  always @(posedge clk) imem_data <= 32'(imem_addr) + 32'd100;

  // Narrow DUT for the wrap test
  logic        rst_w;
  logic [3:0]  imem_addr_w, out_pc_w, out_next_pc_w;
  logic [31:0] imem_data_w, out_instr_w;
  logic        out_valid_w, out_flush_w;
  logic [15:0] bcnt_w, jcnt_w;

  fetch_stage #(.PC_WIDTH(4), .RESET_PC(4'd14)) u_wrap (
    .clk(clk), .rst(rst_w), .in_stall(1'b0),
    .in_branch_taken(1'b0), .in_branch_addr(4'd0),
    .in_is_jump(1'b0), .in_jump_addr(32'd0),
    .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .out_instr(out_instr_w), .out_pc(out_pc_w), .out_next_pc(out_next_pc_w),
    .out_valid(out_valid_w), .out_flush(out_flush_w),
    .out_branch_count(bcnt_w), .out_jump_count(jcnt_w)
  );

  always @(posedge clk) imem_data_w <= 32'(imem_addr_w) + 32'd100;

  int n_tests = 0;
  int n_fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: what the stage will fetch next, which address it is
  // presenting to IF/ID, whether that one is on the correct path, and how
  // many redirects of each kind have been accepted since reset.
  logic [15:0] m_next;
  logic [15:0] m_cur;
  bit          m_cur_ok;
  int          m_nb, m_nj;

  function automatic logic [15:0] exp_count(input int n);
`ifdef FETCH_REDIRECT_STATS_EN
    return (n > 65535) ? 16'hFFFF : 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  // One clock cycle: drive inputs on the falling edge, compare 1 ns later,
  // then advance the model to what the rising edge should produce.
  task automatic step(input bit r, input bit s, input bit bt, input logic [15:0] ba,
                      input bit ij, input logic [31:0] ja);
    bit          redir;
    logic [15:0] tgt;
    bit          valid;
    @(negedge clk);
    rst = r; in_stall = s; in_branch_taken = bt; in_branch_addr = ba;
    in_is_jump = ij; in_jump_addr = ja;
    #1;
    redir = bt | ij;
    tgt   = ij ? ja[15:0] : ba;
    if (r) begin
      check("flush_in_rst", 32'(out_flush), 32'(0));
      m_next = 16'd0; m_cur = 16'd0; m_cur_ok = 0; m_nb = 0; m_nj = 0;
    end else begin
      valid = m_cur_ok && !redir;
      check("imem_addr", 32'(imem_addr), 32'((s && !redir) ? m_cur : m_next));
      check("valid",     32'(out_valid), 32'(valid));
      check("flush",     32'(out_flush), 32'(redir));
      check("pc",        32'(out_pc), 32'(m_cur));
      check("next_pc",   32'(out_next_pc), 32'(16'(m_cur + 16'd1)));
      check("instr",     out_instr, valid ? 32'(m_cur) + 32'd100 : 32'd0);
      check("bcnt",      32'(out_branch_count), 32'(exp_count(m_nb)));
      check("jcnt",      32'(out_jump_count), 32'(exp_count(m_nj)));
      if (redir) begin
        m_cur = m_next; m_next = tgt; m_cur_ok = 0;
        if (ij) m_nj++; else m_nb++;
      end else if (!s) begin
        m_cur = m_next; m_next = m_next + 16'd1; m_cur_ok = 1;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 16'd0, 0, 32'd0);
  endtask

  initial begin
    rst = 1; rst_w = 1; in_stall = 0; in_branch_taken = 0; in_is_jump = 0;
    in_branch_addr = '0; in_jump_addr = '0;
    m_next = 0; m_cur = 0; m_cur_ok = 0; m_nb = 0; m_nj = 0;

    // Reset, then straight-line fetch
    step(1, 0, 0, 16'd0, 0, 32'd0);
    step(1, 0, 0, 16'd0, 0, 32'd0);
    repeat (6) idle();

    // Stall three cycles while out_pc=5
    for (int i = 0; i < 20 && !(m_cur == 16'd5 && m_cur_ok); i++) idle();
    repeat (3) step(0, 1, 0, 16'd0, 0, 32'd0);
    repeat (2) idle();

    // Taken branch to 40 while out_pc=9
    for (int i = 0; i < 20 && !(m_cur == 16'd9 && m_cur_ok); i++) idle();
    step(0, 0, 1, 16'd40, 0, 32'd0);
    repeat (3) idle();

    // Jump + branch + stall together: jump target, stall ignored
    step(0, 1, 1, 16'd7, 1, 32'hFFFF0010);
    repeat (3) idle();

    // Back-to-back redirects: second target wins
    step(0, 0, 1, 16'd100, 0, 32'd0);
    step(0, 0, 0, 16'd0, 1, 32'h0000_00C8);
    repeat (3) idle();

    // Redirect counters: 3 branches and 2 jumps from a clean reset
    step(1, 0, 0, 16'd0, 0, 32'd0);
    idle(); idle();
    step(0, 0, 1, 16'd20, 0, 32'd0); idle(); idle();
    step(0, 0, 0, 16'd0, 1, 32'd30); idle();
    step(0, 1, 1, 16'd50, 0, 32'd0); idle();
    step(0, 0, 1, 16'd60, 1, 32'd70); idle();
    step(0, 0, 1, 16'd80, 0, 32'd0); idle();
    check("bcnt_total", 32'(out_branch_count), 32'(exp_count(3)));
    check("jcnt_total", 32'(out_jump_count), 32'(exp_count(2)));
    step(1, 0, 1, 16'd5, 0, 32'd0);
    idle();
    check("bcnt_cleared", 32'(out_branch_count), 32'd0);
    check("jcnt_cleared", 32'(out_jump_count), 32'd0);

    // Randomized traffic, occasional reset
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           16'($urandom), ($urandom % 12) == 0, $urandom);
    end
    idle();

    // PC wrap on the 4-bit instance: 14, 15, 0, 1
    @(negedge clk);
    rst_w = 0;
    for (int n = 0; n < 6; n++) begin
      logic [3:0] epc;
      #1;
      epc = 4'(14 + n - 1);
      if (n == 0) begin
        check("wrap_valid0", 32'(out_valid_w), 32'd0);
        check("wrap_pc0",    32'(out_pc_w), 32'd14);
        check("wrap_instr0", out_instr_w, 32'd0);
      end else begin
        check("wrap_valid",  32'(out_valid_w), 32'd1);
        check("wrap_pc",     32'(out_pc_w), 32'(epc));
        check("wrap_next",   32'(out_next_pc_w), 32'(4'(epc + 4'd1)));
        check("wrap_instr",  out_instr_w, 32'(epc) + 32'd100);
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
